// File: rtl/serializer_pkg.sv
// -----------------------------------------------------------------------------
// serializer_pkg
// Shared types and defaults for the parallel-in/serial-out serializer.
//   state_t            : IDLE / SHIFT / GAP frame-control states
//   DEFAULT_WIDTH      : default data word width
//   DEFAULT_GAP_CYCLES : default idle gap inserted after each frame
//   even_parity()      : XOR reduction used for the optional parity bit
// -----------------------------------------------------------------------------
package serializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH      = 8;
    localparam int DEFAULT_GAP_CYCLES = 1;

    // Callers zero-extend their word; the extra zeros do not change the XOR.
    function automatic logic even_parity(input logic [63:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/serial_gap_counter.sv
// -----------------------------------------------------------------------------
// serial_gap_counter
// Loadable down-counter that times the idle gap between frames.
// Ports:
//   clk      : system clock
//   rst      : asynchronous active-low reset
//   load     : load load_val into the counter this cycle
//   load_val : number of gap cycles to count
//   done     : high while the counter sits on its final cycle (count == 1)
// -----------------------------------------------------------------------------
module serial_gap_counter #(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The owner leaves GAP on the cycle this is seen, so a load of N
    // yields exactly N cycles spent in GAP.
    assign done = (count_q == CNT_W'(1));

endmodule

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
// Accepts one WIDTH-bit word per valid/ready handshake and shifts it out
// MSB-first, one bit per clock, followed by GAP_CYCLES idle cycles.
// Optional build macro SERIALIZER_PARITY_EN appends an even-parity bit after
// the data LSB (frame becomes WIDTH+1 bits, sr_last marks the parity bit).
// Ports:
//   clk         : system clock
//   rst         : asynchronous active-low reset
//   par_in      : parallel word to serialize
//   par_valid   : par_in holds a valid word
//   par_ready   : block can accept a word this cycle
//   sr_out      : serial data bit
//   sr_valid    : sr_out carries a frame bit
//   frame_start : pulse with the first bit of a frame
//   sr_last     : pulse with the last bit of a frame
//   busy        : frame in progress (SHIFT or GAP)
// All outputs are registered.
// -----------------------------------------------------------------------------
module piso_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] par_in,
    input  logic             par_valid,
    output logic             par_ready,
    output logic             sr_out,
    output logic             sr_valid,
    output logic             frame_start,
    output logic             sr_last,
    output logic             busy
);

`ifdef SERIALIZER_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CNT_W = $clog2(WIDTH + 2);
    localparam int GAP_W = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);

    state_t           state_q,       state_d;
    logic [WIDTH-1:0] shreg_q,       shreg_d;
    logic [CNT_W-1:0] bit_cnt_q,     bit_cnt_d;
    logic             sr_out_q,      sr_out_d;
    logic             sr_valid_q,    sr_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             sr_last_q,     sr_last_d;
    logic             busy_q,        busy_d;
    logic             par_ready_q,   par_ready_d;
`ifdef SERIALIZER_PARITY_EN
    logic             parity_q,      parity_d;
`endif
    logic             gap_load;
    logic             gap_done;

    serial_gap_counter #(
        .CNT_W (GAP_W)
    ) u_gap_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (gap_load),
        .load_val (GAP_W'(GAP_CYCLES)),
        .done     (gap_done)
    );

    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        bit_cnt_d     = bit_cnt_q;
        sr_out_d      = 1'b0;
        sr_valid_d    = 1'b0;
        frame_start_d = 1'b0;
        sr_last_d     = 1'b0;
        busy_d        = 1'b0;
        par_ready_d   = 1'b0;
        gap_load      = 1'b0;
`ifdef SERIALIZER_PARITY_EN
        parity_d      = parity_q;
`endif
        case (state_q)
            IDLE: begin
                // Accept only against the registered ready, so the first
                // edge after reset merely raises par_ready.
                if (par_ready_q && par_valid) begin
                    state_d       = SHIFT;
                    // MSB goes out immediately; the register keeps the rest.
                    shreg_d       = {par_in[WIDTH-2:0], 1'b0};
                    bit_cnt_d     = '0;
                    sr_out_d      = par_in[WIDTH-1];
                    sr_valid_d    = 1'b1;
                    frame_start_d = 1'b1;
                    busy_d        = 1'b1;
`ifdef SERIALIZER_PARITY_EN
                    parity_d      = even_parity(64'(par_in));
`endif
                end else begin
                    par_ready_d = 1'b1;
                end
            end
            SHIFT: begin
                // bit_cnt_q is the index of the bit currently on sr_out.
                if (bit_cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                    bit_cnt_d = '0;
                    if (GAP_CYCLES > 0) begin
                        state_d  = GAP;
                        busy_d   = 1'b1;
                        gap_load = 1'b1;
                    end else begin
                        state_d     = IDLE;
                        par_ready_d = 1'b1;
                    end
                end else begin
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    shreg_d    = {shreg_q[WIDTH-2:0], 1'b0};
                    sr_out_d   = shreg_q[WIDTH-1];
`ifdef SERIALIZER_PARITY_EN
                    if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
                        sr_out_d = parity_q;
                    end
`endif
                    sr_valid_d = 1'b1;
                    busy_d     = 1'b1;
                    sr_last_d  = (bit_cnt_q == CNT_W'(FRAME_LEN - 2));
                end
            end
            GAP: begin
                busy_d = 1'b1;
                if (gap_done) begin
                    state_d     = IDLE;
                    busy_d      = 1'b0;
                    par_ready_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            sr_out_q      <= 1'b0;
            sr_valid_q    <= 1'b0;
            frame_start_q <= 1'b0;
            sr_last_q     <= 1'b0;
            busy_q        <= 1'b0;
            par_ready_q   <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            parity_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            bit_cnt_q     <= bit_cnt_d;
            sr_out_q      <= sr_out_d;
            sr_valid_q    <= sr_valid_d;
            frame_start_q <= frame_start_d;
            sr_last_q     <= sr_last_d;
            busy_q        <= busy_d;
            par_ready_q   <= par_ready_d;
`ifdef SERIALIZER_PARITY_EN
            parity_q      <= parity_d;
`endif
        end
    end

    assign par_ready   = par_ready_q;
    assign sr_out      = sr_out_q;
    assign sr_valid    = sr_valid_q;
    assign frame_start = frame_start_q;
    assign sr_last     = sr_last_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
// Directed bench for piso_serializer. Two instances share clk/rst:
//   dut  : WIDTH=8, GAP_CYCLES=1
//   dut0 : WIDTH=8, GAP_CYCLES=0 (back-to-back frames)
// Honours SERIALIZER_PARITY_EN for the expected frame length and parity bit.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

`ifdef SERIALIZER_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] par_in,  par_in0;
    logic       par_valid, par_valid0;
    logic       par_ready, sr_out, sr_valid, frame_start, sr_last, busy;
    logic       par_ready0, sr_out0, sr_valid0, frame_start0, sr_last0, busy0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    piso_serializer #(.WIDTH(8), .GAP_CYCLES(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .par_in      (par_in),
        .par_valid   (par_valid),
        .par_ready   (par_ready),
        .sr_out      (sr_out),
        .sr_valid    (sr_valid),
        .frame_start (frame_start),
        .sr_last     (sr_last),
        .busy        (busy)
    );

    piso_serializer #(.WIDTH(8), .GAP_CYCLES(0)) dut0 (
        .clk         (clk),
        .rst         (rst),
        .par_in      (par_in0),
        .par_valid   (par_valid0),
        .par_ready   (par_ready0),
        .sr_out      (sr_out0),
        .sr_valid    (sr_valid0),
        .frame_start (frame_start0),
        .sr_last     (sr_last0),
        .busy        (busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (par_ready !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check({tag, "_ready"}, 32'(par_ready), 32'd1);
    endtask

    // Hands a word to dut; returns at the sample point showing bit 0.
    task automatic accept(input string tag, input logic [7:0] word);
        wait_ready(tag);
        par_in    = word;
        par_valid = 1'b1;
        step();
        par_valid = 1'b0;
    endtask

    // Checks a full frame on dut starting with bit 0 visible, then the gap
    // cycle and the return to IDLE. mid_idx >= 0 presents mid_word with
    // par_valid high from that bit onward.
    task automatic run_frame(input string tag, input logic [7:0] word, input logic exp_par,
                             input int mid_idx, input logic [7:0] mid_word);
        logic [7:0] sipo = 8'h00;
        logic       exp_bit;
        for (int i = 0; i < FL; i++) begin
            exp_bit = (i < 8) ? word[7-i] : exp_par;
            check($sformatf("%s_b%0d_out", tag, i),   32'(sr_out),      32'(exp_bit));
            check($sformatf("%s_b%0d_vld", tag, i),   32'(sr_valid),    32'd1);
            check($sformatf("%s_b%0d_start", tag, i), 32'(frame_start), 32'(i == 0));
            check($sformatf("%s_b%0d_last", tag, i),  32'(sr_last),     32'(i == FL - 1));
            check($sformatf("%s_b%0d_rdy", tag, i),   32'(par_ready),   32'd0);
            check($sformatf("%s_b%0d_busy", tag, i),  32'(busy),        32'd1);
            if (i < 8) sipo = {sipo[6:0], sr_out};
            if (i == mid_idx) begin
                par_in    = mid_word;
                par_valid = 1'b1;
            end
            step();
        end
        check({tag, "_sipo"},     32'(sipo),      32'(word));
        check({tag, "_gap_vld"},  32'(sr_valid),  32'd0);
        check({tag, "_gap_out"},  32'(sr_out),    32'd0);
        check({tag, "_gap_busy"}, 32'(busy),      32'd1);
        check({tag, "_gap_rdy"},  32'(par_ready), 32'd0);
        check({tag, "_gap_last"}, 32'(sr_last),   32'd0);
        step();
        check({tag, "_idle_rdy"},  32'(par_ready), 32'd1);
        check({tag, "_idle_busy"}, 32'(busy),      32'd0);
        check({tag, "_idle_vld"},  32'(sr_valid),  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        int t1;
        int n;
        rst        = 1'b0;
        par_in     = 8'h00;
        par_valid  = 1'b0;
        par_in0    = 8'h00;
        par_valid0 = 1'b0;

        // Reset, then idle
        #16;
        check("rst_rdy",   32'(par_ready),   32'd0);
        check("rst_out",   32'(sr_out),      32'd0);
        check("rst_vld",   32'(sr_valid),    32'd0);
        check("rst_busy",  32'(busy),        32'd0);
        check("rst_start", 32'(frame_start), 32'd0);
        check("rst_last",  32'(sr_last),     32'd0);
        check("rst_rdy0",  32'(par_ready0),  32'd0);
        #1 rst = 1'b1;
        #1;
        check("rel_rdy_early", 32'(par_ready), 32'd0);
        step();
        check("rel_rdy",   32'(par_ready),  32'd1);
        check("rel_out",   32'(sr_out),     32'd0);
        check("rel_vld",   32'(sr_valid),   32'd0);
        check("rel_busy",  32'(busy),       32'd0);
        check("rel_rdy0",  32'(par_ready0), 32'd1);

        // Back-to-back FF then 00 on the zero-gap instance
        n = 0;
        while (par_ready0 !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check("b2b_ready", 32'(par_ready0), 32'd1);
        par_in0    = 8'hFF;
        par_valid0 = 1'b1;
        step();
        t0 = cyc;
        for (int i = 0; i < FL; i++) begin
            check($sformatf("b2b_ff_b%0d_out", i),   32'(sr_out0),      32'(i < 8));
            check($sformatf("b2b_ff_b%0d_vld", i),   32'(sr_valid0),    32'd1);
            check($sformatf("b2b_ff_b%0d_start", i), 32'(frame_start0), 32'(i == 0));
            check($sformatf("b2b_ff_b%0d_last", i),  32'(sr_last0),     32'(i == FL - 1));
            check($sformatf("b2b_ff_b%0d_rdy", i),   32'(par_ready0),   32'd0);
            if (i == 0) par_in0 = 8'h00;
            step();
        end
        check("b2b_hole_vld",  32'(sr_valid0),  32'd0);
        check("b2b_hole_rdy",  32'(par_ready0), 32'd1);
        check("b2b_hole_busy", 32'(busy0),      32'd0);
        step();
        t1 = cyc;
        check("b2b_pitch", 32'(t1 - t0), 32'(FL + 1));
        par_valid0 = 1'b0;
        for (int i = 0; i < FL; i++) begin
            check($sformatf("b2b_00_b%0d_out", i),   32'(sr_out0),      32'd0);
            check($sformatf("b2b_00_b%0d_vld", i),   32'(sr_valid0),    32'd1);
            check($sformatf("b2b_00_b%0d_start", i), 32'(frame_start0), 32'(i == 0));
            check($sformatf("b2b_00_b%0d_last", i),  32'(sr_last0),     32'(i == FL - 1));
            step();
        end
        check("b2b_end_vld", 32'(sr_valid0),  32'd0);
        check("b2b_end_rdy", 32'(par_ready0), 32'd1);
        step();
        check("b2b_once_vld", 32'(sr_valid0), 32'd0);

        // Single word A5 (parity 0)
        accept("a5", 8'hA5);
        run_frame("a5", 8'hA5, 1'b0, -1, 8'h00);

        // par_in changes mid-frame: 3C still goes out, C3 waits for IDLE
        accept("3c", 8'h3C);
        run_frame("3c", 8'h3C, 1'b0, 3, 8'hC3);
        accept("c3", 8'hC3);
        run_frame("c3", 8'hC3, 1'b0, -1, 8'h00);

        // Reset pulsed low at bit 4 of 81
        accept("81a", 8'h81);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("81a_b%0d_out", i), 32'(sr_out), 32'(i == 0));
            step();
        end
        check("81a_b4_vld", 32'(sr_valid), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_vld",   32'(sr_valid),    32'd0);
        check("mid_rst_busy",  32'(busy),        32'd0);
        check("mid_rst_last",  32'(sr_last),     32'd0);
        check("mid_rst_start", 32'(frame_start), 32'd0);
        check("mid_rst_rdy",   32'(par_ready),   32'd0);
        check("mid_rst_out",   32'(sr_out),      32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("mid_rst_c%0d_last", i), 32'(sr_last),  32'd0);
            check($sformatf("mid_rst_c%0d_vld", i),  32'(sr_valid), 32'd0);
        end
        rst = 1'b1;
        step();
        check("mid_rel_rdy", 32'(par_ready), 32'd1);
        accept("81b", 8'h81);
        run_frame("81b", 8'h81, 1'b0, -1, 8'h00);

        // Parity words: 07 -> parity 1, 03 -> parity 0
        accept("07", 8'h07);
        run_frame("07", 8'h07, 1'b1, -1, 8'h00);
        accept("03", 8'h03);
        run_frame("03", 8'h03, 1'b0, -1, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
